// File: rtl/mem_pkg.sv
// Shared types and constants for waitstate_memory: FSM state encoding,
// wait-counter width and the byte-lane count helper.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int WCNT_W = 4;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Storage-only single-port array: synchronous read, byte-masked write.
// rdata updates only on an enabled read and holds otherwise.
module mem_array
  import mem_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [lane_count(DW)-1:0]   be,
  input  logic [$clog2(DEPTH)-1:0]    addr,
  input  logic [DW-1:0]               wdata,
  output logic [DW-1:0]               rdata
);

  localparam int NB = lane_count(DW);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; contents are undefined until written, which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/waitstate_memory.sv
// Single-port memory with valid/ready request handshake, WAIT_STATES extra
// cycles per access and byte enables. Define MEM_ADDR_CHECK_EN to flag
// addresses >= DEPTH as errors; otherwise addresses wrap modulo DEPTH.
module waitstate_memory
  import mem_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AW-1:0]             req_addr,
  input  logic [DW-1:0]             req_wdata,
  input  logic [lane_count(DW)-1:0] req_be,
  output logic                      rsp_valid,
  output logic [DW-1:0]             rsp_rdata,
  output logic                      rsp_err
);

  localparam int                IW        = $clog2(DEPTH);
  localparam int                NB        = lane_count(DW);
  localparam bit                ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);

  state_e            state_q;
  logic [WCNT_W-1:0] cnt_q;
  logic              ready_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [NB-1:0]     be_q;
  logic              rsp_valid_q;
  logic              rd_sel_q;

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [AW-1:0]     c_addr;
  logic [DW-1:0]     c_wdata;
  logic [NB-1:0]     c_be;
  logic              c_oob;
  logic [DW-1:0]     arr_rdata;

  assign accept = req_valid && ready_q;

  // With no wait states the access commits on the accept edge straight from
  // the request inputs; otherwise it commits from the captured copy.
  assign commit  = ZERO_WAIT ? accept    : (state_q == WAIT && cnt_q == WCNT_W'(1));
  assign c_we    = ZERO_WAIT ? req_we    : we_q;
  assign c_addr  = ZERO_WAIT ? req_addr  : addr_q;
  assign c_wdata = ZERO_WAIT ? req_wdata : wdata_q;
  assign c_be    = ZERO_WAIT ? req_be    : be_q;

`ifdef MEM_ADDR_CHECK_EN
  logic rsp_err_q;

  assign c_oob = ({1'b0, c_addr} >= (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsp_err_q <= 1'b0;
    else      rsp_err_q <= commit && c_oob;
  end

  assign rsp_err = rsp_err_q;
`else
  assign c_oob   = 1'b0;
  assign rsp_err = 1'b0;

  if (IW < AW) begin : g_addr_hi
    logic addr_hi_unused;
    assign addr_hi_unused = ^c_addr[AW-1:IW];
  end
`endif

  mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (commit && !c_oob),
    .we    (c_we),
    .be    (c_be),
    .addr  (c_addr[IW-1:0]),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      rsp_valid_q <= commit;
      // rd_sel_q steers the array output onto rsp_rdata only after a good read,
      // so writes and errors respond with zero and the value holds between responses.
      if (commit) rd_sel_q <= !c_we && !c_oob;

      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (!ZERO_WAIT) begin
              cnt_q   <= WAIT_INIT;
              state_q <= WAIT;
              ready_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - WCNT_W'(1);
          if (cnt_q == WCNT_W'(1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_waitstate_memory.sv
// Bench for waitstate_memory: three instances (0, 1 and 3 wait states) driven
// with directed and random requests and compared against a word/byte model.
module tb_waitstate_memory;

  localparam int NI       = 3;
  localparam int WS [NI]  = '{0, 1, 3};

  logic        clk;
  logic        rst;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [15:0] req_addr  [NI];
  logic [15:0] req_wdata [NI];
  logic [1:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic [15:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int n_checks;
  int n_errors;

  // Behavioural model: word contents plus per-byte "has been written" flags.
  logic [15:0] model_mem   [NI][256];
  logic [1:0]  model_known [NI][256];

  waitstate_memory #(.DW(16), .AW(16), .DEPTH(256), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  waitstate_memory #(.DW(16), .AW(16), .DEPTH(256), .WAIT_STATES(1)) dut_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  waitstate_memory #(.DW(16), .AW(16), .DEPTH(256), .WAIT_STATES(3)) dut_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected response for one access; updates the model for in-range writes.
  function automatic void model_access(input int d, input logic we, input logic [15:0] addr,
                                       input logic [15:0] wdata, input logic [1:0] be,
                                       output logic [15:0] exp_rdata, output logic exp_err,
                                       output bit exp_known);
    int idx;
    bit oob;
`ifdef MEM_ADDR_CHECK_EN
    oob = (addr >= 16'd256);
`else
    oob = 1'b0;
`endif
    idx       = int'(addr) % 256;
    exp_err   = oob;
    exp_rdata = 16'h0000;
    exp_known = 1'b1;
    if (!oob) begin
      if (we) begin
        for (int i = 0; i < 2; i++) begin
          if (be[i]) begin
            model_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
            model_known[d][idx][i]      = 1'b1;
          end
        end
      end else begin
        exp_rdata = model_mem[d][idx];
        exp_known = &model_known[d][idx];
      end
    end
  endfunction

  // One request on instance d; called and returns at a falling edge.
  // Checks handshake, latency and single-cycle strobe; returns the response.
  task automatic do_req(input int d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        output logic [15:0] rdata, output logic err);
    int  k;
    bit  got;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (req_ready[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_wait inst=%0d req_ready=%b required=1", d, req_ready[d]);
    end
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    if (WS[d] > 0) begin
      n_checks++;
      if (req_ready[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL ready_low inst=%0d req_ready=%b required=0", d, req_ready[d]);
      end
    end
    got = 1'b0;
    for (k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || k != WS[d]) begin
      n_errors++;
      $display("FAIL latency inst=%0d got_rsp=%0d cycles=%0d required=%0d", d, got, k, WS[d]);
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    @(negedge clk);
    n_checks++;
    if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== rdata) begin
      n_errors++;
      $display("FAIL rsp_hold inst=%0d rsp_valid=%b rdata=%h required valid=0 rdata=%h",
               d, rsp_valid[d], rsp_rdata[d], rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < NI; d++) begin
        req_valid[d] = 1'($urandom);
        req_we[d]    = 1'($urandom);
        req_addr[d]  = 16'($urandom);
        req_wdata[d] = 16'($urandom);
        req_be[d]    = 2'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < NI; d++) begin
        n_checks++;
        if ({rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== 18'h0) begin
          n_errors++;
          $display("FAIL reset_outputs inst=%0d valid=%b err=%b rdata=%h required 0/0/0000",
                   d, rsp_valid[d], rsp_err[d], rsp_rdata[d]);
        end
      end
    end
    for (int d = 0; d < NI; d++) req_valid[d] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_release inst=%0d ready=%b valid=%b required 1/0",
                 d, req_ready[d], rsp_valid[d]);
      end
    end
  endtask

  task automatic test_wait1_write_read();
    logic [15:0] r, er;
    logic        e, ee;
    bit          ek;
    model_access(1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, er, ee, ek);
    do_req(1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, r, e);
    n_checks++;
    if (r !== 16'h0000 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL w1_write_rsp rdata=%h err=%b required 0000/0", r, e);
    end
    model_access(1, 1'b0, 16'h0010, 16'h0, 2'b00, er, ee, ek);
    do_req(1, 1'b0, 16'h0010, 16'h0, 2'b00, r, e);
    n_checks++;
    if (r !== 16'hBEEF || e !== 1'b0) begin
      n_errors++;
      $display("FAIL w1_read_rsp rdata=%h err=%b required beef/0", r, e);
    end
  endtask

  task automatic test_byte_enables();
    logic [15:0] r, er;
    logic        e, ee;
    bit          ek;
    model_access(1, 1'b1, 16'h0011, 16'h1234, 2'b11, er, ee, ek);
    do_req(1, 1'b1, 16'h0011, 16'h1234, 2'b11, r, e);
    model_access(1, 1'b1, 16'h0011, 16'hABCD, 2'b01, er, ee, ek);
    do_req(1, 1'b1, 16'h0011, 16'hABCD, 2'b01, r, e);
    model_access(1, 1'b0, 16'h0011, 16'h0, 2'b00, er, ee, ek);
    do_req(1, 1'b0, 16'h0011, 16'h0, 2'b00, r, e);
    n_checks++;
    if (r !== 16'h12CD) begin
      n_errors++;
      $display("FAIL be_low_lane rdata=%h required 12cd", r);
    end
    model_access(1, 1'b1, 16'h0011, 16'hFFFF, 2'b00, er, ee, ek);
    do_req(1, 1'b1, 16'h0011, 16'hFFFF, 2'b00, r, e);
    n_checks++;
    if (r !== 16'h0000 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL be_zero_rsp rdata=%h err=%b required 0000/0", r, e);
    end
    model_access(1, 1'b1, 16'h0011, 16'h5AA5, 2'b10, er, ee, ek);
    do_req(1, 1'b1, 16'h0011, 16'h5AA5, 2'b10, r, e);
    model_access(1, 1'b0, 16'h0011, 16'h0, 2'b00, er, ee, ek);
    do_req(1, 1'b0, 16'h0011, 16'h0, 2'b00, r, e);
    n_checks++;
    if (r !== 16'h5ACD) begin
      n_errors++;
      $display("FAIL be_high_lane rdata=%h required 5acd", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prev_exp, er;
    logic        prev_we, ee;
    bit          ek;
    prev_exp = 16'h0;
    prev_we  = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) begin
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b1) begin
          n_errors++;
          $display("FAIL b2b_strobe step=%0d rsp_valid=%b ready=%b required 1/1",
                   i, rsp_valid[0], req_ready[0]);
        end
        n_checks++;
        if (rsp_rdata[0] !== (prev_we ? 16'h0000 : prev_exp)) begin
          n_errors++;
          $display("FAIL b2b_data step=%0d rdata=%h required %h",
                   i, rsp_rdata[0], prev_we ? 16'h0000 : prev_exp);
        end
      end
      if (i < 32) begin
        req_valid[0] = 1'b1;
        req_we[0]    = (i % 2 == 0);
        req_addr[0]  = 16'(i / 2);
        req_wdata[0] = 16'($urandom);
        req_be[0]    = 2'b11;
        model_access(0, req_we[0], req_addr[0], req_wdata[0], req_be[0], er, ee, ek);
        prev_exp = er;
        prev_we  = req_we[0];
      end else begin
        req_valid[0] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (rsp_valid[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_drain rsp_valid=%b required 0", rsp_valid[0]);
    end
  endtask

  task automatic test_range();
    logic [15:0] r, er;
    logic        e, ee;
    bit          ek;
    model_access(0, 1'b1, 16'h0000, 16'h7777, 2'b11, er, ee, ek);
    do_req(0, 1'b1, 16'h0000, 16'h7777, 2'b11, r, e);
    model_access(0, 1'b1, 16'h0100, 16'h5555, 2'b11, er, ee, ek);
    do_req(0, 1'b1, 16'h0100, 16'h5555, 2'b11, r, e);
    model_access(0, 1'b0, 16'h0000, 16'h0, 2'b00, er, ee, ek);
`ifdef MEM_ADDR_CHECK_EN
    n_checks++;
    if (e !== 1'b1 || r !== 16'h0000) begin
      n_errors++;
      $display("FAIL range_err err=%b rdata=%h required 1/0000", e, r);
    end
    do_req(0, 1'b0, 16'h0000, 16'h0, 2'b00, r, e);
    n_checks++;
    if (r !== 16'h7777 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL range_untouched rdata=%h err=%b required 7777/0", r, e);
    end
`else
    n_checks++;
    if (e !== 1'b0 || r !== 16'h0000) begin
      n_errors++;
      $display("FAIL range_wrap_rsp err=%b rdata=%h required 0/0000", e, r);
    end
    do_req(0, 1'b0, 16'h0000, 16'h0, 2'b00, r, e);
    n_checks++;
    if (r !== 16'h5555 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL range_wrap_data rdata=%h err=%b required 5555/0", r, e);
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] r, er, a, wd;
    logic        e, ee, we;
    logic [1:0]  be;
    bit          ek;
    for (int d = 0; d < NI; d++) begin
      for (int t = 0; t < 30; t++) begin
        we = 1'($urandom);
        a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(250, 270))
                                         : 16'($urandom_range(0, 31));
        wd = 16'($urandom);
        be = 2'($urandom);
        model_access(d, we, a, wd, be, er, ee, ek);
        do_req(d, we, a, wd, be, r, e);
        n_checks++;
        if (e !== ee || (ek && r !== er)) begin
          n_errors++;
          $display("FAIL random inst=%0d txn=%0d we=%b addr=%h rdata=%h err=%b required %h/%b",
                   d, t, we, a, r, e, er, ee);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] r, er;
    logic        e, ee;
    bit          ek;
    model_access(2, 1'b1, 16'h0020, 16'h1111, 2'b11, er, ee, ek);
    do_req(2, 1'b1, 16'h0020, 16'h1111, 2'b11, r, e);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 16'h0020;
    req_wdata[2] = 16'h9999;
    req_be[2]    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid[2] !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_mid_wait_strobe cycle=%0d rsp_valid=%b required 0", c, rsp_valid[2]);
      end
    end
    n_checks++;
    if (req_ready[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_wait_ready req_ready=%b required 1", req_ready[2]);
    end
    model_access(2, 1'b0, 16'h0020, 16'h0, 2'b00, er, ee, ek);
    do_req(2, 1'b0, 16'h0020, 16'h0, 2'b00, r, e);
    n_checks++;
    if (r !== 16'h1111) begin
      n_errors++;
      $display("FAIL rst_mid_wait_data rdata=%h required 1111", r);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int d = 0; d < NI; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      for (int a = 0; a < 256; a++) begin
        model_mem[d][a]   = 16'h0;
        model_known[d][a] = 2'b00;
      end
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_wait1_write_read();
    test_byte_enables();
    test_back_to_back();
    test_range();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/waitstate_memory.md
# waitstate_memory

Parametrised single-port synchronous memory with a valid/ready request interface, programmable wait states and per-byte write enables. Successor to the fixed 16-bit fetch/data memory. Serves as instruction or data memory for the pipelined MIPS core and models slower memory through WAIT_STATES. Every accepted request produces exactly one single-cycle response.

## Interface
- DW, 16: data width in bits; multiple of 8.
- AW, 16: request address width (word address).
- DEPTH, 256: number of DW-bit words; power of two, ≤ 2^AW.
- WAIT_STATES, 1: extra cycles per access, 0..15.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  word address.
- req_wdata  input  DW  write data.
- req_be  input  DW/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response strobe, one cycle per accepted request.
- rsp_rdata  output  DW  read data; 0 for writes and errored requests.
- rsp_err  output  1  address out of range (see Configuration).

## Operation
- Accept: req_valid && req_ready at a rising edge captures we/addr/wdata/be into request registers.
- FSM states: IDLE, WAIT.
  - IDLE: req_ready=1. On accept: if WAIT_STATES=0, commit at the same edge and stay in IDLE; else load wait counter with WAIT_STATES and go to WAIT.
  - WAIT: req_ready=0. Counter decrements each edge. At the edge where the counter equals 1, commit and return to IDLE.
- Commit: the access happens at the commit edge.
  - Read: rsp_rdata gets mem[addr] as it was before that edge.
  - Write: lanes with be[i]=1 are updated; other lanes are unchanged. be=0 is a legal no-op write that still responds.
  - rsp_valid=1 for the one cycle after the commit edge.
- No response backpressure: the consumer must take the response in that cycle.
- Array contents are not touched by rst; contents after power-up are X.
- Reset mid-operation: asserting rst drops a pending WAIT request without committing. FSM goes to IDLE, counter to 0, rsp_valid to 0.

## Timing
- Reset values: req_ready=1 (once released), rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, counter 0.
- Latency: accept at edge T, commit at edge T+WAIT_STATES, rsp_valid high in cycle (T+W, T+W+1).
- req_ready is low from edge T to edge T+W when W>0. It is high again in the response cycle, so the next accept can coincide with rsp_valid.
- Throughput: one request per WAIT_STATES+1 cycles. W=0 gives full rate, back-to-back.
- Back-to-back write then read to the same address (W=0): the read commits one edge later and returns the new data.
- rsp_rdata holds its value when rsp_valid=0. It is valid only while rsp_valid=1.

## Configuration
- MEM_ADDR_CHECK_EN defined: req_addr ≥ DEPTH is treated as an error.
  - No array write.
  - rsp_rdata=0, rsp_err=1 alongside rsp_valid.
  - Normal latency applies.
- MEM_ADDR_CHECK_EN undefined: req_addr is truncated to log2(DEPTH) bits, so addresses wrap around.
  - rsp_err is tied to 0.
  - No comparison logic is generated.

## Structure
- Package mem_pkg holds:
  - FSM state enum (IDLE, WAIT).
  - Wait-counter width constant (4 bits).
  - Helper function computing the byte-lane count DW/8.
- Sub-module mem_array holds storage only.
  - Parameters DW/DEPTH.
  - Ports: clk, en, we, be, addr, wdata, rdata.
  - Synchronous read; byte-masked write.
  - waitstate_memory contains the handshake, FSM, counter and range check.

## Test plan
- Reset/idle: hold rst=0 with random inputs. rsp_valid=0, rsp_err=0, rsp_rdata=0. After release, req_ready=1.
- W=1 write/read: write addr 0x0010 data 0xBEEF be=2'b11 at edge T. req_ready=0 in cycle T. rsp_valid at T+1 with rdata=0. Read 0x0010 then returns 0xBEEF one cycle after its commit.
- Byte enables (DW=16): preload 0x1234, write 0xABCD be=2'b01, read back. Expect 0x12CD.
- Back-to-back at W=0: alternate writes and reads of 0x0000..0x000F every cycle. One rsp_valid per cycle; each read returns the value from the prior write.
- Range, DEPTH=256, macro defined: write 0x0100 data 0x5555 → rsp_err=1, rdata=0. Read 0x0000 unchanged. Macro undefined: same write lands in 0x0000 with rsp_err=0.
- Reset mid-WAIT (W=3): accept a write to 0x0020, assert rst after 1 cycle. No rsp_valid, and 0x0020 retains its old data on a later read.
